// File: rtl/blink_monitor.sv
// blink_monitor: measures the transition-to-transition count of an asynchronous toggling line,
// declares lock on the expected rate and pulses on a stuck line. Optional: BLINK_MONITOR_DUTY_CHECK_EN.
module blink_monitor #(
    parameter int  CLK_FREQ_KHz = 50000,
    parameter int  LED_FREQ_Hz  = 1,
    parameter int  TOL_CYC      = 2,
    parameter int  LOCK_COUNT   = 3,
    localparam int HALF_PERIOD  = (CLK_FREQ_KHz * 1000) / (LED_FREQ_Hz * 2),
    localparam int CNT_MAX      = 2 * HALF_PERIOD,
    localparam int CNT_W        = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    output logic             led_sync,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck,
    output logic             duty_err
);
    typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_e;

    localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [31:0]       LO_BOUND  = (HALF_PERIOD > TOL_CYC) ? 32'(HALF_PERIOD - TOL_CYC) : 32'd0;
    localparam logic [31:0]       HI_BOUND  = 32'(HALF_PERIOD + TOL_CYC);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

    state_e            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, half_q, half_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic              meas_q, meas_d, locked_q, locked_d, stuck_q, stuck_d;
    logic              led_edge, cnt_sat, in_tol;

    assign led_edge = s2_q ^ s3_q;
    assign cnt_sat  = (cnt_q == CNT_SAT);
    assign good_inc = good_q + GOOD_W'(1);
    // A saturated count may hide a much longer gap, so it never counts as in tolerance.
    assign in_tol   = (32'(cnt_q) >= LO_BOUND) && (32'(cnt_q) <= HI_BOUND) && !cnt_sat;

    // NOTE: sync flops reset to 1, the blinker's reset level, so leaving reset creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            state_q  <= ACQ;
            cnt_q    <= '0;
            half_q   <= '0;
            good_q   <= '0;
            meas_q   <= 1'b0;
            locked_q <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so the synchronizer chain shifts by exactly one stage per clock.
            s1_q     <= led_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            good_q   <= good_d;
            meas_q   <= meas_d;
            locked_q <= locked_d;
            stuck_q  <= stuck_d;
        end
    end

    // NOTE: every target gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        good_d  = good_q;
        if (led_edge)     cnt_d = CNT_W'(1);
        else if (!cnt_sat) cnt_d = cnt_q + CNT_W'(1);
        unique case (state_q)
            ACQ: if (led_edge) state_d = TRACK;
            TRACK: begin
                if (led_edge) begin
                    half_d = cnt_q;
                    if (in_tol) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LOCK) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end else if (cnt_sat) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (led_edge) begin
                    half_d = cnt_q;
                    if (!in_tol) begin
                        state_d = TRACK;
                        good_d  = '0;
                    end
                end else if (cnt_sat) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            default: state_d = ACQ;
        endcase
    end

    always_comb begin
        meas_d   = led_edge && (state_q != ACQ);
        stuck_d  = !led_edge && cnt_sat && (state_q != ACQ);
        locked_d = (state_d == LOCKED);
    end

    assign led_sync    = s2_q;
    assign half_period = half_q;
    assign meas_valid  = meas_q;
    assign locked      = locked_q;
    assign stuck       = stuck_q;

`ifdef BLINK_MONITOR_DUTY_CHECK_EN
    logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d, duty_diff;
    logic             hi_seen_q, hi_seen_d, lo_seen_q, lo_seen_d, duty_q, duty_d;

    // s3 still holds the level of the phase that just ended.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_seen_d = hi_seen_q;
        lo_seen_d = lo_seen_q;
        duty_d    = duty_q;
        duty_diff = '0;
        if (led_edge && state_q == ACQ) begin
            hi_seen_d = 1'b0;
            lo_seen_d = 1'b0;
        end else if (meas_d) begin
            if (s3_q) begin
                hi_d      = cnt_q;
                hi_seen_d = 1'b1;
            end else begin
                lo_d      = cnt_q;
                lo_seen_d = 1'b1;
            end
            duty_diff = (hi_d >= lo_d) ? (hi_d - lo_d) : (lo_d - hi_d);
            if (hi_seen_d && lo_seen_d) duty_d = (32'(duty_diff) > 32'(TOL_CYC));
        end else if (stuck_d) begin
            duty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            hi_seen_q <= 1'b0;
            lo_seen_q <= 1'b0;
            duty_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_seen_q <= hi_seen_d;
            lo_seen_q <= lo_seen_d;
            duty_q    <= duty_d;
        end
    end

    assign duty_err = duty_q;
`else
    assign duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor: stimulus pushes expected measurement/stuck events,
// a negedge monitor pops and compares whenever meas_valid or stuck is presented.
module tb_blink_monitor;
    localparam int CNT_W = 4;  // CNT_MAX = 10 for the parameters below
`ifdef BLINK_MONITOR_DUTY_CHECK_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    typedef struct {
        bit is_stuck;
        int hp;
        bit lk;
        bit de;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             led_in;
    logic             led_sync;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             stuck;
    logic             duty_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    blink_monitor #(
        .CLK_FREQ_KHz(1),
        .LED_FREQ_Hz (100),
        .TOL_CYC     (1),
        .LOCK_COUNT  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .led_sync   (led_sync),
        .half_period(half_period),
        .meas_valid (meas_valid),
        .locked     (locked),
        .stuck      (stuck),
        .duty_err   (duty_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait n clocks, toggle the line; if this edge ends a measured interval, expect its event.
    task automatic edge_after(input int n, input bit meas, input int hp, input bit lk, input bit de);
        repeat (n) @(posedge clk);
        #2 led_in = ~led_in;
        if (meas) exp_q.push_back('{is_stuck: 1'b0, hp: hp, lk: lk, de: de & DUTY_ON});
    endtask

    // Hold the line: exactly one stuck pulse expected, with lock and duty flag cleared.
    task automatic hold_stuck();
        exp_q.push_back('{is_stuck: 1'b1, hp: 0, lk: 1'b0, de: 1'b0});
        repeat (25) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && (meas_valid || stuck)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event meas_valid=%0b stuck=%0b half_period=%0d (t=%0t)",
                         meas_valid, stuck, half_period, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_stuck", int'(stuck), int'(mon_e.is_stuck));
                if (!mon_e.is_stuck) check("half_period", int'(half_period), mon_e.hp);
                check("locked_at_event", int'(locked), int'(mon_e.lk));
                check("duty_err_at_event", int'(duty_err), int'(mon_e.de));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        led_in = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_led_sync", int'(led_sync), 1);
        check("rst_half_period", int'(half_period), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_stuck", int'(stuck), 0);
        check("rst_duty_err", int'(duty_err), 0);
        rst = 1'b0;

        // 5-clk toggling: first edge only acquires, lock on the 4th edge.
        edge_after(3, 0, 0, 0, 0);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 1, 0);
        edge_after(5, 1, 5, 1, 0);
        edge_after(5, 1, 5, 1, 0);
        // One 8-clk high phase drops lock; three 5-clk halves relock.
        edge_after(8, 1, 8, 0, 1);
        edge_after(5, 1, 5, 0, 1);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 1, 0);
        // Line held: single stuck pulse, then relock after 4 edges.
        hold_stuck();
        edge_after(3, 0, 0, 0, 0);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 1, 0);
        hold_stuck();
        // 6-clk: inside tolerance.
        edge_after(3, 0, 0, 0, 0);
        edge_after(6, 1, 6, 0, 0);
        edge_after(6, 1, 6, 0, 0);
        edge_after(6, 1, 6, 1, 0);
        hold_stuck();
        // 4-clk: inside tolerance.
        edge_after(3, 0, 0, 0, 0);
        edge_after(4, 1, 4, 0, 0);
        edge_after(4, 1, 4, 0, 0);
        edge_after(4, 1, 4, 1, 0);
        hold_stuck();
        // 7-clk: outside tolerance, never locks; then an edge exactly at saturation.
        edge_after(3, 0, 0, 0, 0);
        edge_after(7, 1, 7, 0, 0);
        edge_after(7, 1, 7, 0, 0);
        edge_after(7, 1, 7, 0, 0);
        edge_after(7, 1, 7, 0, 0);
        edge_after(10, 1, 10, 0, 1);
        hold_stuck();

        // Lock again, then reset asynchronously between clock edges.
        edge_after(3, 0, 0, 0, 0);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 0, 0);
        edge_after(5, 1, 5, 1, 0);
        edge_after(5, 1, 5, 1, 0);
        repeat (6) @(posedge clk);
        check("pre_reset_locked", int'(locked), 1);
        check("pre_reset_led_sync", int'(led_sync), 0);
        #3 rst = 1'b1;
        #1;
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_meas_valid", int'(meas_valid), 0);
        check("async_rst_half_period", int'(half_period), 0);
        check("async_rst_led_sync", int'(led_sync), 1);
        led_in = 1'b1;
        repeat (2) @(negedge clk);
        check("in_rst_led_sync", int'(led_sync), 1);
        rst = 1'b0;

        // Duty: high 4 / low 6, then 5 / 5.
        edge_after(3, 0, 0, 0, 0);
        edge_after(6, 1, 6, 0, 0);
        edge_after(4, 1, 4, 0, 1);
        edge_after(6, 1, 6, 1, 1);
        edge_after(4, 1, 4, 1, 1);
        edge_after(5, 1, 5, 1, 0);
        edge_after(5, 1, 5, 1, 0);
        repeat (6) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
